// File: rtl/fme_cost_selector.sv
// Tracks the minimum accumulated FME candidate cost over one search round and reports its index.
// Optional macro FME_TIE_LAST_EN: equal costs favour the later candidate instead of the earlier one.
module fme_cost_selector #(
   parameter int DATAWIDTH = 8,
   parameter int NUM_CAND  = 9,
   parameter int IDXWIDTH  = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   cost_valid,
   input  logic [DATAWIDTH+8:0]   cost_in,
   output logic                   busy,
   output logic                   done,
   output logic [IDXWIDTH-1:0]    best_idx,
   output logic [DATAWIDTH+8:0]   best_cost
);

   localparam int CW = DATAWIDTH + 9;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [IDXWIDTH-1:0]   cnt_q, cnt_d;
   logic [IDXWIDTH-1:0]   min_idx_q, min_idx_d;
   logic [IDXWIDTH-1:0]   best_idx_q, best_idx_d;
   logic [CW-1:0]         min_q, min_d;
   logic [CW-1:0]         best_cost_q, best_cost_d;
   logic                  last;
   logic                  take;

   function automatic logic cost_wins(input logic [CW-1:0] c, input logic [CW-1:0] m);
`ifdef FME_TIE_LAST_EN
      return c <= m;
`else
      return c < m;
`endif
   endfunction

   assign last = (cnt_q == IDXWIDTH'(NUM_CAND - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      min_d       = min_q;
      min_idx_d   = min_idx_q;
      best_idx_d  = best_idx_q;
      best_cost_d = best_cost_q;
      take        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COLLECT;
               cnt_d   = '0;
            end
         end
         COLLECT: begin
            // A start here aborts the round; any cost offered alongside it is dropped.
            if (start) begin
               cnt_d = '0;
            end else if (cost_valid) begin
               take = (cnt_q == '0) || cost_wins(cost_in, min_q);
               if (take) begin
                  min_d     = cost_in;
                  min_idx_d = cnt_q;
               end
               cnt_d = cnt_q + IDXWIDTH'(1);
               if (last) begin
                  state_d     = DONE;
                  cnt_d       = '0;
                  best_cost_d = take ? cost_in : min_q;
                  best_idx_d  = take ? cnt_q : min_idx_q;
               end
            end
         end
         DONE: begin
            state_d = start ? COLLECT : IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         min_q       <= '0;
         min_idx_q   <= '0;
         best_idx_q  <= '0;
         best_cost_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         min_q       <= min_d;
         min_idx_q   <= min_idx_d;
         best_idx_q  <= best_idx_d;
         best_cost_q <= best_cost_d;
      end
   end

   assign busy      = (state_q == COLLECT);
   assign done      = (state_q == DONE);
   assign best_idx  = best_idx_q;
   assign best_cost = best_cost_q;

endmodule
